// File: rtl/ref_pkg.sv
// ref_pkg: shared geometry and loader state type for the reference Bank pair
package ref_pkg;
    localparam int PIXEL = 8;
    localparam int LANES = 8;
    localparam int DEPTH = 96;
    localparam int AW = 7;
    localparam int DW = PIXEL * LANES;
    typedef enum logic [1:0] {IDLE, FILL, WAIT} ld_state_t;
endpackage

// File: rtl/pp_flag_tracker.sv
// pp_flag_tracker: ping-pong bank_full flags with same-cycle release lookahead
module pp_flag_tracker (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       set,
    input  logic       cur,
    input  logic [1:0] rel,
    output logic [1:0] full,
    output logic       next_free,
    output logic       cur_free
);
    logic [1:0] full_next;
    // releases clear, completing fill sets cur; the two never hit the same bit
    always_comb full_next = (full & ~rel) | ({1'b0, set} << cur);
    assign next_free = ~full_next[~cur];
    assign cur_free = ~full_next[cur];
    // flag register, wiped by flush
    always_ff @(posedge clk or posedge rst)
        if (rst) full <= '0;
        else full <= flush ? 2'b00 : full_next;
endmodule

// File: rtl/ref_bank_loader.sv
// ref_bank_loader: streams fetch words into alternating reference Banks
module ref_bank_loader
    import ref_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          beg_en,
    output logic          Bank_sel,
    output logic [DW-1:0] ref_in,
    output logic [AW-1:0] wr_addr,
    output logic [1:0]    bank_full,
    input  logic [1:0]    bank_release
);
    ld_state_t state;
    logic cur, accept, last, next_free, cur_free;
    logic [AW-1:0] cnt;
    assign in_ready = (state == FILL) & ~flush;
    assign accept = in_valid & in_ready;
    assign last = cnt == AW'(DEPTH - 1);
    pp_flag_tracker u_flags (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .set(accept & last),
        .cur(cur),
        .rel(bank_release),
        .full(bank_full),
        .next_free(next_free),
        .cur_free(cur_free)
    );
    // FSM, word counter and registered Bank write port
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            cur <= 1'b0;
            cnt <= '0;
            beg_en <= 1'b0;
            Bank_sel <= 1'b0;
            ref_in <= '0;
            wr_addr <= '0;
        end else if (flush) begin
            state <= FILL;
            cur <= 1'b0;
            cnt <= '0;
            beg_en <= 1'b0;
        end else begin
            beg_en <= accept;
            if (accept) begin
                ref_in <= in_data;
                Bank_sel <= cur;
                wr_addr <= cnt;
                cnt <= last ? '0 : cnt + AW'(1);
                cur <= last ? ~cur : cur;
            end
            state <= state == IDLE ? FILL :
                     state == WAIT ? (cur_free ? FILL : WAIT) :
                     (accept & last & ~next_free) ? WAIT : FILL;
        end
endmodule
